// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped tagged BTB with saturating direction counters
//
// Purpose: combinational branch prediction from the IF-stage PC, trained by
// resolved conditional branches from ID. Counters are indexed bimodally
// (GHR_W=0) or with gshare (idx XOR global history, GHR_W>0). A saturating
// 32-bit counter tracks mispredictions.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   lookup_pc         IF-stage PC to predict for
//   pred_hit          BTB valid and tag match for lookup_pc
//   pred_taken        pred_hit and counter MSB set
//   pred_target       stored target when pred_taken, else lookup_pc+4
//   upd_valid         a resolved conditional branch is presented
//   upd_pc            PC of the resolved branch
//   upd_taken         actual direction
//   upd_target        actual taken target
//   upd_mispredict    resolution disagreed with the prediction
//   miss_count        saturating misprediction count

module branch_predictor_btb #(
  parameter int ADDR_W     = 64,
  parameter int ENTRIES    = 16,
  parameter int TAG_W      = 8,
  parameter int CNT_W      = 2,
  parameter int GHR_W      = 0,
  parameter int INST_ALIGN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  output logic [31:0]       miss_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_W'(1);

  logic              valid   [ENTRIES];
  logic [TAG_W-1:0]  tag_arr [ENTRIES];
  logic [ADDR_W-1:0] tgt_arr [ENTRIES];
  logic [CNT_W-1:0]  cnt     [ENTRIES];
  logic [31:0]       miss_q;

  logic [IDX_W-1:0]  l_idx, u_idx, l_cidx, u_cidx, ghr_ext;
  logic [TAG_W-1:0]  l_tag, u_tag;
  logic              u_hit;
  logic [CNT_W-1:0]  cnt_cur, cnt_next;

  // Only the index and tag fields of the PCs are used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, upd_pc};

  assign l_idx = lookup_pc[INST_ALIGN +: IDX_W];
  assign l_tag = lookup_pc[INST_ALIGN + IDX_W +: TAG_W];
  assign u_idx = upd_pc[INST_ALIGN +: IDX_W];
  assign u_tag = upd_pc[INST_ALIGN + IDX_W +: TAG_W];

  generate
    if (GHR_W == 0) begin : g_bimodal
      assign ghr_ext = '0;
    end else begin : g_gshare
      logic [GHR_W-1:0] ghr;
      always_ff @(posedge clk) begin
        if (reset) begin
          ghr <= '0;
        end else if (upd_valid) begin
          // Truncating {ghr, taken} drops the oldest bit; also covers GHR_W=1.
          ghr <= GHR_W'({ghr, upd_taken});
        end
      end
      assign ghr_ext = IDX_W'(ghr);
    end
  endgenerate

  assign l_cidx = l_idx ^ ghr_ext;
  assign u_cidx = u_idx ^ ghr_ext;

  // Lookup: no bypass from a same-cycle update.
  assign pred_hit    = valid[l_idx] && (tag_arr[l_idx] == l_tag);
  assign pred_taken  = pred_hit && cnt[l_cidx][CNT_W-1];
  assign pred_target = pred_taken ? tgt_arr[l_idx] : lookup_pc + ADDR_W'(4);
  assign miss_count  = miss_q;

  assign u_hit   = valid[u_idx] && (tag_arr[u_idx] == u_tag);
  assign cnt_cur = cnt[u_cidx];

  // A taken branch that misses the BTB allocates a fresh entry, so its
  // counter restarts at weakly-taken rather than training the old value.
  always_comb begin
    cnt_next = cnt_cur;
    if (upd_taken) begin
      if (!u_hit) begin
        cnt_next = CNT_WEAK_T;
      end else if (cnt_cur != CNT_MAX) begin
        cnt_next = cnt_cur + CNT_W'(1);
      end
    end else if (cnt_cur != '0) begin
      cnt_next = cnt_cur - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]   <= 1'b0;
        tag_arr[i] <= '0;
        tgt_arr[i] <= '0;
        cnt[i]     <= CNT_WEAK_NT;
      end
      miss_q <= '0;
    end else if (upd_valid) begin
      cnt[u_cidx] <= cnt_next;
      if (upd_taken) begin
        valid[u_idx]   <= 1'b1;
        tag_arr[u_idx] <= u_tag;
        tgt_arr[u_idx] <= upd_target;
      end
      if (upd_mispredict && (miss_q != 32'hFFFF_FFFF)) begin
        miss_q <= miss_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - self-checking bench for branch_predictor_btb
module tb_branch_predictor_btb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] lookup_pc [2];
  logic [63:0] upd_pc [2];
  logic [63:0] upd_target [2];
  logic [63:0] pred_target [2];
  logic        upd_valid [2];
  logic        upd_taken [2];
  logic        upd_mispredict [2];
  logic        pred_hit [2];
  logic        pred_taken [2];
  logic [31:0] miss_count [2];

  branch_predictor_btb #(.GHR_W(0)) dut_a (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc[0]),
    .pred_hit(pred_hit[0]), .pred_taken(pred_taken[0]), .pred_target(pred_target[0]),
    .upd_valid(upd_valid[0]), .upd_pc(upd_pc[0]), .upd_taken(upd_taken[0]),
    .upd_target(upd_target[0]), .upd_mispredict(upd_mispredict[0]),
    .miss_count(miss_count[0])
  );

  branch_predictor_btb #(.GHR_W(4)) dut_b (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc[1]),
    .pred_hit(pred_hit[1]), .pred_taken(pred_taken[1]), .pred_target(pred_target[1]),
    .upd_valid(upd_valid[1]), .upd_pc(upd_pc[1]), .upd_taken(upd_taken[1]),
    .upd_target(upd_target[1]), .upd_mispredict(upd_mispredict[1]),
    .miss_count(miss_count[1])
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  bit started = 0;

  // Model state: 16 entries, 2-bit counters held as integers 0..3.
  bit          m_valid [2][16];
  int          m_tag   [2][16];
  logic [63:0] m_tgt   [2][16];
  int          m_cnt   [2][16];
  int          m_ghr   [2];
  logic [31:0] m_miss  [2];

  function automatic int gw(int i);
    return (i == 0) ? 0 : 4;
  endfunction

  function automatic int f_idx(logic [63:0] pc);
    return int'((pc >> 2) % 64'd16);
  endfunction

  function automatic int f_tag(logic [63:0] pc);
    return int'((pc >> 6) % 64'd256);
  endfunction

  function automatic int f_cidx(int i, logic [63:0] pc);
    if (gw(i) == 0) return f_idx(pc);
    return f_idx(pc) ^ (m_ghr[i] % (1 << gw(i)));
  endfunction

  function automatic bit f_hit(int i, logic [63:0] pc);
    return m_valid[i][f_idx(pc)] && (m_tag[i][f_idx(pc)] == f_tag(pc));
  endfunction

  function automatic bit f_taken(int i, logic [63:0] pc);
    return f_hit(i, pc) && (m_cnt[i][f_cidx(i, pc)] >= 2);
  endfunction

  function automatic logic [63:0] f_target(int i, logic [63:0] pc);
    return f_taken(i, pc) ? m_tgt[i][f_idx(pc)] : pc + 64'd4;
  endfunction

  task automatic model_update(int i);
    int ix;
    int cx;
    bit h;
    if (reset) begin
      for (int j = 0; j < 16; j++) begin
        m_valid[i][j] = 0;
        m_tag[i][j] = 0;
        m_tgt[i][j] = '0;
        m_cnt[i][j] = 1;
      end
      m_ghr[i] = 0;
      m_miss[i] = '0;
      return;
    end
    if (!upd_valid[i]) return;
    ix = f_idx(upd_pc[i]);
    cx = f_cidx(i, upd_pc[i]);
    h = f_hit(i, upd_pc[i]);
    if (upd_taken[i]) begin
      m_cnt[i][cx] = h ? ((m_cnt[i][cx] < 3) ? m_cnt[i][cx] + 1 : 3) : 2;
      m_valid[i][ix] = 1;
      m_tag[i][ix] = f_tag(upd_pc[i]);
      m_tgt[i][ix] = upd_target[i];
    end else begin
      m_cnt[i][cx] = (m_cnt[i][cx] > 0) ? m_cnt[i][cx] - 1 : 0;
    end
    if (gw(i) > 0) m_ghr[i] = ((m_ghr[i] << 1) | int'(upd_taken[i])) % (1 << gw(i));
    if (upd_mispredict[i] && (m_miss[i] != 32'hFFFF_FFFF)) m_miss[i] = m_miss[i] + 32'd1;
  endtask

  always @(posedge clk) begin
    model_update(0);
    model_update(1);
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Compare process: both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_hit[%0d]", i), 64'(pred_hit[i]), 64'(f_hit(i, lookup_pc[i])));
        chk($sformatf("model_taken[%0d]", i), 64'(pred_taken[i]), 64'(f_taken(i, lookup_pc[i])));
        chk($sformatf("model_target[%0d]", i), pred_target[i], f_target(i, lookup_pc[i]));
        chk($sformatf("model_miss[%0d]", i), 64'(miss_count[i]), 64'(m_miss[i]));
      end
    end
  end

  task automatic step(int i, logic [63:0] lpc, logic uv, logic [63:0] upc,
                      logic ut, logic [63:0] utg, logic um);
    @(negedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      upd_valid[j] = 1'b0;
      upd_mispredict[j] = 1'b0;
    end
    lookup_pc[i] = lpc;
    upd_valid[i] = uv;
    upd_pc[i] = upc;
    upd_taken[i] = ut;
    upd_target[i] = utg;
    upd_mispredict[i] = um;
    #1;
  endtask

  task automatic lk(int i, logic [63:0] pc);
    step(i, pc, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic upd(int i, logic [63:0] pc, logic t, logic [63:0] tg, logic m);
    step(i, pc, 1'b1, pc, t, tg, m);
  endtask

  task automatic expect_pred(string n, int i, logic h, logic t, logic [63:0] tg);
    chk({n, "_hit"}, 64'(pred_hit[i]), 64'(h));
    chk({n, "_taken"}, 64'(pred_taken[i]), 64'(t));
    chk({n, "_target"}, pred_target[i], tg);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int j = 0; j < 2; j++) begin
      lookup_pc[j] = '0; upd_pc[j] = '0; upd_target[j] = '0;
      upd_valid[j] = 0; upd_taken[j] = 0; upd_mispredict[j] = 0;
    end
    repeat (2) @(posedge clk);
    started = 1;
    @(negedge clk);
    #1 reset = 1'b0;

    // Reset state
    lk(0, 64'h100);
    expect_pred("reset", 0, 0, 0, 64'h104);
    chk("reset_miss", 64'(miss_count[0]), 64'h0);

    // Allocation and counter training
    upd(0, 64'h100, 1, 64'h200, 1);
    lk(0, 64'h100);
    expect_pred("alloc", 0, 1, 1, 64'h200);
    chk("alloc_miss", 64'(miss_count[0]), 64'h1);
    upd(0, 64'h100, 1, 64'h200, 0);
    lk(0, 64'h100);
    expect_pred("cnt3", 0, 1, 1, 64'h200);
    upd(0, 64'h100, 0, 64'h0, 1);
    lk(0, 64'h100);
    expect_pred("cnt2", 0, 1, 1, 64'h200);
    upd(0, 64'h100, 0, 64'h0, 0);
    lk(0, 64'h100);
    expect_pred("cnt1", 0, 1, 0, 64'h104);
    upd(0, 64'h100, 0, 64'h0, 0);
    lk(0, 64'h100);
    expect_pred("cnt0", 0, 1, 0, 64'h104);
    upd(0, 64'h100, 0, 64'h0, 0);
    lk(0, 64'h100);
    expect_pred("cnt0_sat", 0, 1, 0, 64'h104);
    upd(0, 64'h100, 1, 64'h200, 0);
    lk(0, 64'h100);
    expect_pred("hit_inc", 0, 1, 0, 64'h104);
    upd(0, 64'h100, 1, 64'h200, 0);
    lk(0, 64'h100);
    expect_pred("hit_inc2", 0, 1, 1, 64'h200);
    step(0, 64'h100, 1'b0, 64'h100, 1'b0, 64'h0, 1'b1);
    lk(0, 64'h100);
    chk("miss_unqualified", 64'(miss_count[0]), 64'h2);

    // Aliasing: 0x100 and 0x140 share idx 0
    do_reset();
    upd(0, 64'h100, 1, 64'h200, 0);
    upd(0, 64'h140, 1, 64'h240, 0);
    lk(0, 64'h100);
    expect_pred("alias_old", 0, 0, 0, 64'h104);
    lk(0, 64'h140);
    expect_pred("alias_new", 0, 1, 1, 64'h240);

    // Same-cycle lookup/update: no bypass
    do_reset();
    upd(0, 64'h100, 1, 64'h200, 0);
    expect_pred("same_cycle", 0, 0, 0, 64'h104);
    lk(0, 64'h100);
    expect_pred("next_cycle", 0, 1, 1, 64'h200);

    // Not-taken never allocates
    do_reset();
    upd(0, 64'h100, 0, 64'h200, 0);
    lk(0, 64'h100);
    expect_pred("nt_noalloc", 0, 0, 0, 64'h104);

    // Reset drops a coincident update
    upd(0, 64'h180, 1, 64'h280, 1);
    lk(0, 64'h180);
    expect_pred("pre_reset", 0, 1, 1, 64'h280);
    chk("pre_reset_miss", 64'(miss_count[0]), 64'h1);
    reset = 1'b1;
    upd(0, 64'h1C0, 1, 64'h2C0, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    lk(0, 64'h1C0);
    expect_pred("reset_drop", 0, 0, 0, 64'h1C4);
    chk("reset_drop_miss", 64'(miss_count[0]), 64'h0);
    lk(0, 64'h180);
    expect_pred("reset_clear", 0, 0, 0, 64'h184);

    // miss_count saturation
    @(negedge clk);
    #1;
    upd_valid[0] = 1'b1; upd_pc[0] = 64'h400; upd_taken[0] = 1'b0;
    upd_target[0] = 64'h0; upd_mispredict[0] = 1'b1; lookup_pc[0] = 64'h400;
    force dut_a.miss_q = 32'hFFFF_FFFE;
    m_miss[0] = 32'hFFFF_FFFE;
    #1 release dut_a.miss_q;
    upd(0, 64'h400, 0, 64'h0, 1);
    chk("miss_to_max", 64'(miss_count[0]), 64'hFFFF_FFFF);
    lk(0, 64'h400);
    chk("miss_hold", 64'(miss_count[0]), 64'hFFFF_FFFF);

    // gshare (GHR_W=4): after four taken updates ghr=1111, lookup uses cidx 15
    do_reset();
    for (int k = 0; k < 4; k++) upd(1, 64'h300, 1, 64'h500, 0);
    lk(1, 64'h300);
    expect_pred("gshare_cidx15", 1, 1, 0, 64'h304);
    upd(1, 64'h300, 1, 64'h500, 0);
    lk(1, 64'h300);
    expect_pred("gshare_train15", 1, 1, 1, 64'h500);

    lk(0, 64'h0);
    lk(1, 64'h0);
    started = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised branch prediction unit for the pipelined RISC-V core. It combines a direct-mapped, tagged branch target buffer with a table of N-bit saturating direction counters, selectable between bimodal and gshare indexing. Lookup is combinational from the IF-stage PC. Updates come from branch resolution in ID and take effect on the next clock edge. It also keeps a saturating misprediction counter for performance measurement.

## Interface

Parameters:
- ADDR_W, 64: PC and target width.
- ENTRIES, 16: BTB and counter-table depth. Power of two, ≥2. IDX_W = log2(ENTRIES).
- TAG_W, 8: stored tag width. Requires INST_ALIGN+IDX_W+TAG_W ≤ ADDR_W.
- CNT_W, 2: direction counter width, ≥1.
- GHR_W, 0: global history length. 0 selects bimodal indexing; 1..IDX_W selects gshare.
- INST_ALIGN, 2: number of low PC bits dropped before indexing.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- lookup_pc  in  ADDR_W  IF-stage PC.
- pred_hit  out  1  BTB valid and tag match for lookup_pc.
- pred_taken  out  1  predicted taken (hit AND counter MSB).
- pred_target  out  ADDR_W  stored target if pred_taken, else lookup_pc+4.
- upd_valid  in  1  a resolved conditional branch is presented this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  ADDR_W  actual taken target.
- upd_mispredict  in  1  resolution disagreed with the prediction; qualified by upd_valid.
- miss_count  out  32  number of mispredictions, saturating.

## Operation

- Field extraction, for any pc: idx = pc[INST_ALIGN +: IDX_W]; tag = pc[INST_ALIGN+IDX_W +: TAG_W].
- Counter index:
  - Bimodal: cidx = idx.
  - gshare: cidx = idx XOR zero-extended ghr[GHR_W-1:0].
  - BTB entries are always indexed by idx.
- Lookup is purely combinational:
  - pred_hit = valid[idx] & (tag_arr[idx] == tag).
  - pred_taken = pred_hit & cnt[cidx][CNT_W-1].
  - pred_target wraps modulo 2^ADDR_W.
- Update (upd_valid=1, applied at the clock edge):
  - Counter at cidx(upd_pc) moves +1 if upd_taken, −1 otherwise. It saturates at 2^CNT_W−1 and at 0.
  - cidx is computed with the GHR value from before the edge.
  - If upd_taken: BTB[idx] ← {valid=1, tag, upd_target}. This overwrites any aliasing entry.
  - If the entry was not previously a hit (new allocation), the counter is instead written to weakly-taken, 2^(CNT_W−1), rather than incremented.
  - If not taken: the BTB entry is unchanged. A not-taken update never allocates.
  - GHR (if GHR_W>0) ← {ghr[GHR_W-2:0], upd_taken}. For GHR_W=1, ghr ← upd_taken.
  - miss_count increments if upd_mispredict. It holds at 0xFFFF_FFFF.
- Reset state:
  - All valid bits 0.
  - Counters at weakly-not-taken, 2^(CNT_W−1)−1 (01 for CNT_W=2).
  - GHR 0, miss_count 0.
  - Resulting outputs: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.

## Timing

- Lookup latency: 0 cycles, combinational from lookup_pc.
- Update latency: visible to lookup on the cycle after upd_valid.
- Same-cycle lookup and update to the same idx/cidx: lookup returns pre-update contents. No bypass.
- reset has priority: an update asserted with reset is dropped entirely, including miss_count and GHR.
- reset asserted mid-stream clears state at that edge. Outputs reflect the reset state from the following cycle.
- upd_* inputs are ignored when upd_valid=0, including upd_mispredict.
- No backpressure. One update per cycle is accepted unconditionally.

## Test plan

Defaults apply unless stated: ENTRIES=16, CNT_W=2, GHR_W=0.

- Reset, then lookup 0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, miss_count=0.
- Update pc 0x100, taken, target 0x200 -> next cycle lookup 0x100 gives hit=1, taken=1 (cnt=10), target=0x200. A second taken update makes cnt=11.
- From cnt=11, three not-taken updates at 0x100 -> cnt 10, 01, 00, with taken=0 after the second. Hit stays 1 and target stays 0x200 (internal 0x200, output 0x104). A fourth not-taken update leaves cnt=00.
- Aliasing: taken update at 0x100 then at 0x140 (same idx) -> lookup 0x100 hit=0; lookup 0x140 hit=1, cnt=10.
- Same-cycle lookup/update of 0x100 after reset -> pred_hit=0 that cycle, hit=1 the next. Reset asserted with upd_valid=1 and mispredict=1 -> miss_count=0 and no entry written.
- GHR_W=4: four taken updates at 0x300 give ghr=1111, then lookup 0x300 uses cidx=(0x300>>2 & 0xF) XOR 0xF. Separately, force miss_count to 0xFFFF_FFFF, then a mispredict update -> miss_count holds at 0xFFFF_FFFF.
